fir_lpf_serial: RTL and testbench
=================================

Name: fir_lpf_serial

Overview:
- Parametrised successor to the team's fixed 16-tap, 8-bit low-pass FIR.
- Collects each sample as NIB_W-bit slices, least significant slice first, then shifts it into a TAPS-deep delay line.
- Computes the filter with one serial multiply-accumulate per clock, using runtime-loadable signed coefficients.
- Emits a rounded DATA_W-bit result with a one-cycle y_valid pulse; sits between the nibble-serial ADC interface and downstream sample consumers.

Parameters:
- TAPS, 16, filter length (>=2).
- DATA_W, 8, sample and output width, signed two's complement.
- NIB_W, 4, input slice width; DATA_W % NIB_W == 0; NIBS = DATA_W/NIB_W.
- COEF_W, 16, signed coefficient width.
- FRAC, 12, coefficient fractional bits (Q-format scaling); FRAC >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush of datapath; coefficients retained.
- x_half  in  NIB_W  input sample slice.
- x_valid  in  1  slice present.
- x_ready  out  1  block accepts a slice; slice is taken on x_valid && x_ready.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  coefficient index k.
- coef_wdata  in  COEF_W  coefficient value.
- y_valid  out  1  one-cycle result strobe.
- y  out  DATA_W  filtered sample, held until the next result.

Behaviour:
- Reset and outputs: reset clears all state and outputs. y=0, y_valid=0, x_ready=1. Delay line, accumulator, slice counter and all coefficients are zero. State is COLLECT.
- Arithmetic widths: ACC_W = DATA_W+COEF_W+clog2(TAPS). Each product is a full signed DATA_W x COEF_W multiply, sign-extended to ACC_W. The accumulator never overflows internally.
- COLLECT state: x_ready=1. Each accepted slice fills bits [NIB_W*(n+1)-1 : NIB_W*n] of the assembly register, n = 0..NIBS-1.
  - The edge that accepts slice NIBS-1 also shifts the line: x[k] <= x[k-1] for k>=1, and x[0] <= assembled sample.
  - On the same edge: slice counter <= 0, acc <= 0, tap index <= 0, state <= MAC.
- MAC state: x_ready=0. Each cycle performs acc += x[k]*c[k] and k++.
  - After k = TAPS-1 is accumulated, the next state is OUT.
  - MAC lasts exactly TAPS cycles.
- OUT state (one cycle):
  - y is loaded with r = acc[FRAC+DATA_W-1:FRAC] + acc[FRAC-1], i.e. round half toward +inf, wrapped to DATA_W.
  - y_valid = 1 for exactly this one cycle; the next state is COLLECT.
- Latency: y_valid rises TAPS+1 clocks after the edge accepting the last slice. Sample throughput is one per NIBS+TAPS+1 clocks at minimum.
- Coefficient writes: a write is applied on the clock edge when coef_we=1 and state==COLLECT.
  - coef_we is ignored during MAC and OUT, so c[] is stable for a whole computation.
  - An out-of-range coef_addr (TAPS not a power of 2) is ignored.
- Partial samples: a partial sample (0 < n < NIBS) persists indefinitely while x_valid is low. There is no timeout.
- clr (priority over everything except reset) zeroes on the next edge:
  - the delay line, accumulator, slice counter and y;
  - y_valid, forced to 0.
  - State returns to COLLECT and coefficients are untouched.
- Reset asserted mid-MAC: the computation is aborted immediately and no y_valid is issued.

Optional Feature:
- FIR_SAT_EN defined: the rounded value is computed at full width, acc[ACC_W-1:FRAC] + acc[FRAC-1]. It is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before loading y.
- FIR_SAT_EN undefined: wrap behaviour exactly as in the Behaviour section.

Test Plan:
- Identity: reset, write c[0]=0x1000, all others 0; send slices 0x5 then 0x2 -> y=0x25 with y_valid, TAPS+1=17 clocks after the second slice.
- Rounding: c[0]=0x0800; x=0x03 -> y=0x02; x=0xFD (-3) -> y=0xFF (-1).
- Delay line: c[3]=0x1000 only; send samples 0x10,0,0,0 -> y sequence 0x00,0x00,0x00,0x10.
- Overflow with c[0]=0x7FFF, x=0x7F:
  - FIR_SAT_EN undefined -> y=0xF8.
  - FIR_SAT_EN defined -> y=0x7F.
- Handshake and writes: x_valid held high through MAC -> x_ready=0, no slices consumed. coef_we to c[0] during MAC -> result uses the old c[0].
- Reset/clr: assert reset at MAC cycle 5 -> y=0, y_valid never pulses, x_ready=1. Assert clr after one slice -> next two slices form a fresh sample and the prior history reads as zero.

Source files
------------

// File: rtl/fir_lpf_serial.sv
// Nibble-serial input FIR low-pass filter with one multiply-accumulate per clock.
// Optional clamping of the rounded output is enabled by defining FIR_SAT_EN.
module fir_lpf_serial #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4,
  parameter int COEF_W = 16,
  parameter int FRAC   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic [NIB_W-1:0]          x_half,
  input  logic                      x_valid,
  output logic                      x_ready,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic                      y_valid,
  output logic [DATA_W-1:0]         y
);

  localparam int NIBS   = DATA_W / NIB_W;
  localparam int AW     = $clog2(TAPS);
  localparam int CNT_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MAC     = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t                     state_r;
  logic [CNT_W-1:0]           nib_cnt_r;
  logic [DATA_W-1:0]          asm_r;
  logic signed [DATA_W-1:0]   x_r    [TAPS];
  logic signed [COEF_W-1:0]   coef_r [TAPS];
  logic [AW-1:0]              tap_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic [DATA_W-1:0]          y_r;
  logic                       y_valid_r;
  logic                       x_ready_r;

  logic [DATA_W-1:0]          sample_s;
  logic                       last_slice_s;
  logic                       coef_hit_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic [DATA_W-1:0]          round_s;

  assign x_ready = x_ready_r;
  assign y_valid = y_valid_r;
  assign y       = y_r;

  // Slice assembly and coefficient-write qualification.
  always_comb begin
    sample_s = asm_r;
    sample_s[int'(nib_cnt_r) * NIB_W +: NIB_W] = x_half;
    last_slice_s = (nib_cnt_r == CNT_W'(NIBS - 1));
    coef_hit_s   = coef_we && (int'(coef_addr) < TAPS);
  end

  // Full-precision product of the current tap, sign-extended to accumulator width.
  always_comb begin
    prod_s     = x_r[tap_r] * coef_r[tap_r];
    prod_ext_s = {{AW{prod_s[PROD_W-1]}}, prod_s};
  end

`ifdef FIR_SAT_EN
  localparam int HI_W = ACC_W - FRAC + 1;
  logic [HI_W-1:0] full_s;

  // Round half toward +inf at full width, then clamp into the output range.
  always_comb begin
    full_s = {acc_r[ACC_W-1], acc_r[ACC_W-1:FRAC]} + {{(HI_W-1){1'b0}}, acc_r[FRAC-1]};
    if ((&full_s[HI_W-1:DATA_W-1]) || (~|full_s[HI_W-1:DATA_W-1])) begin
      round_s = full_s[DATA_W-1:0];
    end else if (full_s[HI_W-1]) begin
      round_s = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      round_s = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Round half toward +inf, wrapping to the output width.
  always_comb begin
    round_s = acc_r[FRAC+DATA_W-1:FRAC] + {{(DATA_W-1){1'b0}}, acc_r[FRAC-1]};
  end
`endif

  // Control FSM, delay line, accumulator, coefficient store and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_COLLECT;
      nib_cnt_r <= '0;
      asm_r     <= '0;
      tap_r     <= '0;
      acc_r     <= '0;
      y_r       <= '0;
      y_valid_r <= 1'b0;
      x_ready_r <= 1'b1;
      for (int k = 0; k < TAPS; k++) begin
        x_r[k]    <= '0;
        coef_r[k] <= '0;
      end
    end else if (clr) begin
      state_r   <= ST_COLLECT;
      nib_cnt_r <= '0;
      asm_r     <= '0;
      tap_r     <= '0;
      acc_r     <= '0;
      y_r       <= '0;
      y_valid_r <= 1'b0;
      x_ready_r <= 1'b1;
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
      end
    end else begin
      y_valid_r <= 1'b0;
      case (state_r)
        ST_COLLECT: begin
          if (coef_hit_s) begin
            coef_r[coef_addr] <= coef_wdata;
          end
          if (x_valid) begin
            asm_r <= sample_s;
            if (last_slice_s) begin
              for (int k = TAPS - 1; k >= 1; k--) begin
                x_r[k] <= x_r[k-1];
              end
              x_r[0]    <= sample_s;
              nib_cnt_r <= '0;
              acc_r     <= '0;
              tap_r     <= '0;
              x_ready_r <= 1'b0;
              state_r   <= ST_MAC;
            end else begin
              nib_cnt_r <= nib_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_MAC: begin
          acc_r <= acc_r + prod_ext_s;
          if (tap_r == AW'(TAPS - 1)) begin
            state_r <= ST_OUT;
          end else begin
            tap_r <= tap_r + AW'(1);
          end
        end
        ST_OUT: begin
          y_r       <= round_s;
          y_valid_r <= 1'b1;
          x_ready_r <= 1'b1;
          state_r   <= ST_COLLECT;
        end
        default: begin
          x_ready_r <= 1'b1;
          state_r   <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_lpf_serial.sv
// Self-checking bench for fir_lpf_serial: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_fir_lpf_serial;

  localparam int TAPS   = 16;
  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;
  localparam int COEF_W = 16;
  localparam int FRAC   = 12;
  localparam int NIBS   = DATA_W / NIB_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    clr;
  logic [NIB_W-1:0]        x_half;
  logic                    x_valid;
  logic                    x_ready;
  logic                    coef_we;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic [COEF_W-1:0]       coef_wdata;
  logic                    y_valid;
  logic [DATA_W-1:0]       y;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int               m_hist [TAPS];
  int               m_coef [TAPS];
  int               m_nib;
  logic [DATA_W-1:0] m_asm;
  int               m_busy;
  logic [DATA_W-1:0] m_y;
  logic [DATA_W-1:0] m_pend;
  logic             m_yv;
  logic             m_ready;

  fir_lpf_serial #(
    .TAPS(TAPS), .DATA_W(DATA_W), .NIB_W(NIB_W), .COEF_W(COEF_W), .FRAC(FRAC)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .x_half(x_half), .x_valid(x_valid),
    .x_ready(x_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .y_valid(y_valid), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Dot product of history and coefficients, rounded half up, then wrapped or clamped.
  function automatic logic [DATA_W-1:0] model_result();
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(m_hist[k]) * longint'(m_coef[k]);
    r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef FIR_SAT_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`endif
    return r[DATA_W-1:0];
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin m_hist[k] = 0; m_coef[k] = 0; end
      m_nib = 0; m_asm = '0; m_busy = 0; m_y = '0; m_yv = 1'b0; m_ready = 1'b1;
    end else if (clr) begin
      for (int k = 0; k < TAPS; k++) m_hist[k] = 0;
      m_nib = 0; m_asm = '0; m_busy = 0; m_y = '0; m_yv = 1'b0; m_ready = 1'b1;
    end else begin
      m_yv = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_y = m_pend; m_yv = 1'b1; m_ready = 1'b1;
        end
      end else begin
        if (coef_we && int'(coef_addr) < TAPS) m_coef[coef_addr] = int'($signed(coef_wdata));
        if (x_valid) begin
          m_asm[m_nib*NIB_W +: NIB_W] = x_half;
          m_nib++;
          if (m_nib == NIBS) begin
            for (int k = TAPS - 1; k >= 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = int'($signed(m_asm));
            m_nib = 0;
            m_pend = model_result();
            m_busy = TAPS + 1;
            m_ready = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs 1ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("x_ready", {31'b0, x_ready}, {31'b0, m_ready});
    check("y_valid", {31'b0, y_valid}, {31'b0, m_yv});
    check("y", {24'b0, y}, {24'b0, m_y});
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic write_coef(input int addr, input logic [COEF_W-1:0] val);
    coef_we = 1'b1; coef_addr = addr[$clog2(TAPS)-1:0]; coef_wdata = val;
    step();
    coef_we = 1'b0;
  endtask

  task automatic send_slice(input logic [NIB_W-1:0] v);
    x_valid = 1'b1; x_half = v; step(); x_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] v);
    for (int i = 0; i < NIBS; i++) send_slice(v[i*NIB_W +: NIB_W]);
  endtask

  // Wait (bounded) for the DUT result strobe; returns the cycles taken.
  task automatic wait_result(output int lat);
    lat = 0;
    while (y_valid !== 1'b1 && lat < 100) begin step(); lat++; end
    if (lat >= 100) check("result_timeout", 32'd1, 32'd0);
  endtask

  task automatic sample_expect(input string name, input logic [DATA_W-1:0] v,
                               input logic [DATA_W-1:0] exp);
    int lat;
    send_sample(v);
    wait_result(lat);
    check(name, {24'b0, y}, {24'b0, exp});
  endtask

  initial begin
    int lat;
    reset = 1'b1; clr = 1'b0; x_half = '0; x_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    step();
    reset = 1'b0;
    check("reset_y", {24'b0, y}, 32'h0);
    check("reset_y_valid", {31'b0, y_valid}, 32'h0);
    check("reset_x_ready", {31'b0, x_ready}, 32'h1);

    // Identity and latency
    write_coef(0, 16'h1000);
    send_slice(4'h5);
    send_slice(4'h2);
    wait_result(lat);
    check("identity_y", {24'b0, y}, 32'h25);
    check("identity_latency", lat, TAPS + 1);
    step();
    check("y_valid_one_cycle", {31'b0, y_valid}, 32'h0);
    check("y_held", {24'b0, y}, 32'h25);

    // Rounding
    do_reset();
    write_coef(0, 16'h0800);
    sample_expect("round_pos", 8'h03, 8'h02);
    sample_expect("round_neg", 8'hFD, 8'hFF);

    // Delay line
    do_reset();
    write_coef(3, 16'h1000);
    sample_expect("delay_0", 8'h10, 8'h00);
    sample_expect("delay_1", 8'h00, 8'h00);
    sample_expect("delay_2", 8'h00, 8'h00);
    sample_expect("delay_3", 8'h00, 8'h10);

    // Overflow
    do_reset();
    write_coef(0, 16'h7FFF);
`ifdef FIR_SAT_EN
    sample_expect("overflow_sat", 8'h7F, 8'h7F);
`else
    sample_expect("overflow_wrap", 8'h7F, 8'hF8);
`endif

    // Handshake and coefficient writes during MAC
    do_reset();
    write_coef(0, 16'h1000);
    send_sample(8'h11);
    x_valid = 1'b1; x_half = 4'hF;
    coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'h2000;
    step();
    check("busy_x_ready", {31'b0, x_ready}, 32'h0);
    wait_result(lat);
    x_valid = 1'b0; coef_we = 1'b0;
    check("mac_coef_ignored", {24'b0, y}, 32'h11);
    sample_expect("coef_unchanged", 8'h11, 8'h11);

    // Reset in the middle of MAC
    write_coef(0, 16'h1000);
    send_sample(8'h44);
    repeat (5) step();
    do_reset();
    check("abort_y", {24'b0, y}, 32'h0);
    check("abort_x_ready", {31'b0, x_ready}, 32'h1);
    repeat (TAPS + 4) step();
    check("abort_no_valid", {31'b0, y_valid}, 32'h0);

    // clr after one slice
    write_coef(0, 16'h1000);
    write_coef(1, 16'h1000);
    sample_expect("pre_clr", 8'h20, 8'h20);
    send_slice(4'h7);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_y", {24'b0, y}, 32'h0);
    sample_expect("post_clr", 8'h03, 8'h03);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      x_valid    = ($urandom_range(0, 2) != 0);
      x_half     = NIB_W'($urandom);
      coef_we    = ($urandom_range(0, 5) == 0);
      coef_addr  = $urandom_range(0, TAPS - 1);
      coef_wdata = COEF_W'($urandom);
      clr        = ($urandom_range(0, 150) == 0);
      step();
    end
    x_valid = 1'b0; coef_we = 1'b0; clr = 1'b0;
    repeat (TAPS + 4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
